// File: rtl/mii_rx_framer.sv
// mii_rx_framer: MII nibble stream to framed bytes with preamble/SFD detection, optional FCS strip and per-frame status
module mii_rx_framer #(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int STRIP_FCS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [3:0]  rxd,
  input  logic        rx_err,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [10:0] frame_len
);
  localparam int D = STRIP_FCS ? 5 : 1;
  localparam logic [10:0] DL   = 11'(D);
  localparam logic [10:0] MINL = 11'(MIN_LEN);
  localparam logic [10:0] MAXL = 11'(MAX_LEN);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  state_t      state;
  logic        armed, phase, err, bad;
  logic [3:0]  low;
  logic [10:0] count;
  logic [7:0]  dl [D];
  assign bad = err | phase | (count < MINL);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      phase     <= 1'b0;
      err       <= 1'b0;
      low       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      frame_len <= '0;
      for (int i = 0; i < D; i++) dl[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (!rx_dv) armed <= 1'b1;
      case (state)
        IDLE: if (rx_dv) state <= (armed && rxd == 4'h5) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (!rx_dv || (rxd != 4'h5 && rxd != 4'hd)) state <= IDLE;
          else if (rxd == 4'hd) begin
            state <= DATA;
            phase <= 1'b0;
            count <= '0;
            err   <= 1'b0;
          end
        end
        DATA: begin
          if (rx_dv) begin
            err   <= err | rx_err;
            phase <= ~phase;
            if (!phase) low <= rxd;
            else begin
              count <= (count == 11'h7ff) ? count : count + 11'd1;
              dl[0] <= {rxd, low};
              for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
              if (count >= DL) begin
                out_valid <= 1'b1;
                out_data  <= dl[D-1];
                out_sof   <= count == DL;
              end
              // oversize: close the output frame now and discard the rest
              if (count == MAXL) begin
                out_last  <= 1'b1;
                frame_err <= 1'b1;
                frame_len <= MAXL + 11'd1;
                state     <= DROP;
              end
            end
          end else begin
            state     <= IDLE;
            frame_len <= count;
            frame_ok  <= ~bad;
            frame_err <= bad;
            if (count >= DL) begin
              out_valid <= 1'b1;
              out_data  <= dl[D-1];
              out_sof   <= count == DL;
              out_last  <= 1'b1;
            end
          end
        end
        DROP: if (!rx_dv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mii_rx_framer.sv
// tb_mii_rx_framer: directed frames into two framers (FCS stripped and forwarded) with hand-computed expectations
module tb_mii_rx_framer;
  logic clk = 1'b0, rst = 1'b1, rx_dv = 1'b0, rx_err = 1'b0;
  logic [3:0] rxd = 4'h0;
  logic [7:0] o_data, p_data;
  logic o_valid, o_sof, o_last, o_ok, o_err, p_valid, p_sof, p_last, p_ok, p_err;
  logic [10:0] o_len, p_len;
  int vectors = 0, miscompares = 0, cyc = 0;
  int n, sof_n, sof_idx, last_n, last_idx, st_n, st_ok, st_err, st_len, st_cyc, hi_cyc;
  int n1, last1_n, last1_data, st1_n, st1_ok, st1_len;
  int data [2048];

  mii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .STRIP_FCS(1)) u0 (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd), .rx_err(rx_err),
    .out_data(o_data), .out_valid(o_valid), .out_sof(o_sof), .out_last(o_last),
    .frame_ok(o_ok), .frame_err(o_err), .frame_len(o_len));
  mii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .STRIP_FCS(0)) u1 (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd), .rx_err(rx_err),
    .out_data(p_data), .out_valid(p_valid), .out_sof(p_sof), .out_last(p_last),
    .frame_ok(p_ok), .frame_err(p_err), .frame_len(p_len));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (o_valid) begin
      data[n] = int'(o_data);
      if (o_sof) begin sof_n++; sof_idx = n; end
      if (o_last) begin last_n++; last_idx = n; end
      n++;
    end
    if (o_ok || o_err) begin
      st_n++; st_ok = int'(o_ok); st_err = int'(o_err); st_len = int'(o_len); st_cyc = cyc;
    end
    if (p_valid) begin
      n1++;
      if (p_last) begin last1_n++; last1_data = int'(p_data); end
    end
    if (p_ok || p_err) begin st1_n++; st1_ok = int'(p_ok); st1_len = int'(p_len); end
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear();
    n = 0; sof_n = 0; sof_idx = -1; last_n = 0; last_idx = -1;
    st_n = 0; st_ok = 0; st_err = 0; st_len = -1; st_cyc = -1;
    n1 = 0; last1_n = 0; last1_data = -1; st1_n = 0; st1_ok = 0; st1_len = -1;
  endtask

  task automatic nib(input logic [3:0] v, input logic e = 1'b0);
    @(negedge clk);
    rx_dv = 1'b1; rxd = v; rx_err = e;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      rx_dv = 1'b0; rxd = 4'h0; rx_err = 1'b0;
    end
  endtask

  task automatic bytes(input int nb, input int err_at);
    for (int i = 0; i < nb; i++) begin
      logic [7:0] b;
      b = i[7:0];
      nib(b[3:0], i == err_at);
      nib(b[7:4]);
      if (i == 1518) hi_cyc = cyc;
    end
  endtask

  task automatic frame(input int nb, input bit odd, input int err_at);
    clear();
    repeat (15) nib(4'h5);
    nib(4'hd);
    bytes(nb, err_at);
    if (odd) nib(4'h7);
    idle(6);
  endtask

  task automatic seq_check(input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) if (data[i] != (i & 255)) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    clear();
    #2 rst = 1'b0;
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_len", int'(o_len), 0);
    check("rst_status", int'(o_ok | o_err), 0);
    idle(3);
    rst = 1'b1;
    idle(3);

    frame(64, 1'b0, -1);
    check("f64_n", n, 60);
    seq_check("f64_seq");
    check("f64_sof_n", sof_n, 1);
    check("f64_sof_idx", sof_idx, 0);
    check("f64_last_n", last_n, 1);
    check("f64_last_data", data[59], 8'h3b);
    check("f64_last_idx", last_idx, 59);
    check("f64_st_n", st_n, 1);
    check("f64_ok", st_ok, 1);
    check("f64_len", st_len, 64);
    check("f64_nostrip_n", n1, 64);
    check("f64_nostrip_last", last1_data, 8'h3f);
    check("f64_nostrip_last_n", last1_n, 1);
    check("f64_nostrip_ok", st1_ok, 1);
    check("f64_nostrip_len", st1_len, 64);

    frame(10, 1'b0, -1);
    check("f10_n", n, 6);
    seq_check("f10_seq");
    check("f10_last_idx", last_idx, 5);
    check("f10_err", st_err, 1);
    check("f10_len", st_len, 10);

    frame(3, 1'b0, -1);
    check("f3_n", n, 0);
    check("f3_st_n", st_n, 1);
    check("f3_err", st_err, 1);
    check("f3_len", st_len, 3);
    check("f3_nostrip_n", n1, 3);

    frame(100, 1'b0, 20);
    check("rxerr_n", n, 96);
    seq_check("rxerr_seq");
    check("rxerr_err", st_err, 1);
    check("rxerr_ok", st_ok, 0);
    check("rxerr_len", st_len, 100);

    frame(64, 1'b1, -1);
    check("odd_n", n, 60);
    check("odd_err", st_err, 1);
    check("odd_ok", st_ok, 0);
    check("odd_len", st_len, 64);

    clear();
    repeat (8) nib(4'h5);
    nib(4'h3);
    repeat (16) nib(4'ha);
    idle(6);
    check("badpre_n", n, 0);
    check("badpre_st_n", st_n, 0);
    frame(64, 1'b0, -1);
    check("afterbad_ok", st_ok, 1);
    check("afterbad_n", n, 60);

    frame(1600, 1'b0, -1);
    check("big_st_n", st_n, 1);
    check("big_err", st_err, 1);
    check("big_len", st_len, 1519);
    check("big_timing", st_cyc, hi_cyc + 1);
    check("big_n", n, 1514);
    check("big_last_idx", last_idx, 1513);
    check("big_last_data", data[1513], 8'he9);
    check("big_nostrip_len", st1_len, 1519);
    check("big_nostrip_n", n1, 1518);

    clear();
    repeat (15) nib(4'h5);
    nib(4'hd);
    bytes(30, -1);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_data", int'(o_data), 0);
    check("midrst_len", int'(o_len), 0);
    check("midrst_len1", int'(p_len), 0);
    @(negedge clk);
    rst = 1'b1;
    clear();
    repeat (10) nib(4'h5);
    nib(4'hd);
    repeat (40) nib(4'h1);
    idle(6);
    check("midrst_st_n", st_n + st1_n, 0);
    check("midrst_out_n", n + n1, 0);
    frame(64, 1'b0, -1);
    check("postrst_ok", st_ok, 1);
    check("postrst_n", n, 60);
    seq_check("postrst_seq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
